i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
// - I2C target (responder) for the far end of our open-drain I2C master bus; used as a bench/loopback
//   peer and as an on-chip register-port front end. Filters and synchronises SCL/SDA, detects
//   START/STOP, matches a 7-bit address, ACKs, and moves bytes in both directions.
// - Never drives SCL (no clock stretching). SDA is driven low only via sda_oe; top level builds
//   sda = sda_oe ? 1'b0 : 1'bz.
// PARAMETERS
// - ADDR      7'h3C  7-bit target address compared against the first byte after START
// - FILT_LEN  3      consecutive equal synchronised samples needed to accept a new SCL/SDA level (>=1)
// PORTS
// - clk        in   1  system clock (27 MHz; master SCL period = 128 clk)
// - rst        in   1  asynchronous, active-high reset
// - scl_in     in   1  raw SCL pad input (asynchronous)
// - sda_in     in   1  raw SDA pad input (asynchronous)
// - sda_oe     out  1  1 = pull SDA low; 0 = release
// - rx_data    out  8  last byte written by the master; held until next rx_valid
// - rx_valid   out  1  1-clk pulse: rx_data updated with a data byte (address byte never reported)
// - rx_first   out  1  qualifies rx_valid: first data byte since address match
// - tx_data    in   8  byte returned on next master read; sampled on tx_req cycle
// - tx_req     out  1  1-clk pulse: tx_data captured into shift register; user may advance tx_data
// - addressed  out  1  high from address ACK until STOP, repeated START, or master NACK on read
// - stop_det   out  1  1-clk pulse on every STOP seen on bus
// BEHAVIOUR
// - Reset (async): sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, addressed=0, stop_det=0,
//   state=IDLE, filtered scl/sda=1, bit counter=0. Reset mid-transfer releases SDA immediately.
// - Input path: 2-flop synchroniser per line, then filter: filtered level changes only after FILT_LEN
//   consecutive equal samples. Edges (scl_rise, scl_fall, sda_rise, sda_fall) are 1-clk pulses from
//   filtered levels.
// - START: sda_fall while filtered scl=1 -> state ADDR, bit count 0, addressed=0, sda_oe=0; valid from
//   any state (repeated START). STOP: sda_rise while scl=1 -> IDLE, sda_oe=0, addressed=0, stop_det pulse.
//   START/STOP take priority over any same-cycle data activity.
// - Data bits sampled into shift register on scl_rise, MSB first. SDA outputs change only on the
//   clk after scl_fall, never while scl=1.
// - States:
//   IDLE: wait for START.
//   ADDR: shift 8 bits; on 8th scl_rise compare [7:1] with ADDR. Match -> on next scl_fall assert
//     sda_oe (ADDR_ACK). Mismatch -> IGNORE (sda_oe stays 0).
//   ADDR_ACK: addressed=1; on scl_fall ending ACK bit: R/W=0 -> release SDA, WRITE, set rx_first
//     flag; R/W=1 -> capture tx_data, pulse tx_req, drive bit7 (sda_oe=~bit), READ.
//   WRITE: on 8th scl_rise: rx_data<=byte, rx_valid pulse, rx_first=flag, clear flag; next scl_fall
//     assert sda_oe (WRITE_ACK); following scl_fall release, back to WRITE, bit count 0.
//   READ: on each scl_fall drive next bit; after bit0's scl_fall release SDA -> READ_ACK.
//   READ_ACK: sample SDA on scl_rise. 0 (ACK) -> on scl_fall capture tx_data, tx_req pulse, drive
//     bit7, READ. 1 (NACK) -> addressed=0, IGNORE with SDA released.
//   IGNORE: hold SDA released; leave only on START or STOP.
// - Bit counter 3 bits, wraps 7->0 at each byte boundary. rx_valid/tx_req never in same cycle.
// - Glitches shorter than FILT_LEN clk on either line invisible to the FSM.
// TESTING
// - START, 0x78 (0x3C W), 0xA5, 0x00, STOP -> ACK on bits 9,18,27; rx_valid x2 with 0xA5
//   (rx_first=1) then 0x00 (rx_first=0); stop_det pulse; addressed 0 after STOP.
// - START, 0x7A (0x3D W), 0xFF, STOP -> sda_oe never 1; no rx_valid; addressed stays 0.
// - START, 0x79 (0x3C R), tx_data=0x5A then 0xC3, master ACK then NACK -> SDA bits 0x5A, 0xC3;
//   tx_req x2; SDA released after NACK; addressed=0.
// - START, 0x78, 0x11, repeated START, 0x79, read 1 byte NACK, STOP -> rx_valid 0x11, then read
//   phase returns tx_data, addressed re-asserted after 2nd address ACK.
// - SDA low glitch of FILT_LEN-1 clk while SCL high in IDLE -> no START; FILT_LEN clk -> START.
// - rst asserted while sda_oe=1 in ADDR_ACK -> sda_oe=0 same cycle, IDLE; next clean write works.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target (responder) with filtered SCL/SDA inputs, START/STOP detection,
// 7-bit address match, and byte transfers in both directions. SCL is never
// driven; SDA is only ever pulled low through o_sda_oe.
module i2c_target #(
    parameter logic [6:0] ADDR     = 7'h3C,
    parameter int         FILT_LEN = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_sda_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_first,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic       o_addressed,
    output logic       o_stop_det
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_END,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_END,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_READ_NEXT,
        S_IGNORE
    } state_t;

    logic [1:0]    r_sclSync;
    logic [1:0]    r_sdaSync;
    logic          r_sclFilt;
    logic          r_sdaFilt;
    logic [CW-1:0] r_sclCnt;
    logic [CW-1:0] r_sdaCnt;
    logic          r_sclPrev;
    logic          r_sdaPrev;

    state_t        r_state;
    state_t        w_stateNext;

    logic          r_sdaOe;
    logic [7:0]    r_rxData;
    logic          r_rxValid;
    logic          r_rxFirst;
    logic          r_txReq;
    logic          r_addressed;
    logic          r_stopDet;
    logic [6:0]    r_shift;
    logic [2:0]    r_bitCnt;
    logic          r_firstFlag;
    logic [6:0]    r_txShift;

    logic          w_sdaOeNext;
    logic [7:0]    w_rxDataNext;
    logic          w_rxValidNext;
    logic          w_rxFirstNext;
    logic          w_txReqNext;
    logic          w_addressedNext;
    logic          w_stopDetNext;
    logic [6:0]    w_shiftNext;
    logic [2:0]    w_bitCntNext;
    logic          w_firstFlagNext;
    logic [6:0]    w_txShiftNext;

    logic          w_sclRise;
    logic          w_sclFall;
    logic          w_sdaRise;
    logic          w_sdaFall;
    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_byte;

    // Two-flop synchronisers bring the asynchronous pads into the clock domain; idle bus is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
        end else begin
            r_sclSync <= {r_sclSync[0], i_scl_in};
            r_sdaSync <= {r_sdaSync[0], i_sda_in};
        end
    end

    // SCL filter: adopt a new level only after FILT_LEN consecutive samples disagree with the current one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclFilt <= 1'b1;
            r_sclCnt  <= '0;
        end else if (r_sclSync[1] == r_sclFilt) begin
            r_sclCnt  <= '0;
        end else if (r_sclCnt == CNT_MAX) begin
            r_sclFilt <= r_sclSync[1];
            r_sclCnt  <= '0;
        end else begin
            r_sclCnt  <= r_sclCnt + 1'b1;
        end
    end

    // SDA filter: same acceptance rule as SCL so short glitches never reach the FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sdaFilt <= 1'b1;
            r_sdaCnt  <= '0;
        end else if (r_sdaSync[1] == r_sdaFilt) begin
            r_sdaCnt  <= '0;
        end else if (r_sdaCnt == CNT_MAX) begin
            r_sdaFilt <= r_sdaSync[1];
            r_sdaCnt  <= '0;
        end else begin
            r_sdaCnt  <= r_sdaCnt + 1'b1;
        end
    end

    // Delayed copies of the filtered levels turn level changes into single-cycle edge pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclPrev <= r_sclFilt;
            r_sdaPrev <= r_sdaFilt;
        end
    end

    assign w_sclRise = r_sclFilt & ~r_sclPrev;
    assign w_sclFall = ~r_sclFilt & r_sclPrev;
    assign w_sdaRise = r_sdaFilt & ~r_sdaPrev;
    assign w_sdaFall = ~r_sdaFilt & r_sdaPrev;
    assign w_start   = w_sdaFall & r_sclFilt;
    assign w_stop    = w_sdaRise & r_sclFilt;
    assign w_byte    = {r_shift, r_sdaFilt};

    // State register for the bus protocol FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and datapath decisions; START/STOP override whatever the current state would do.
    always_comb begin
        w_stateNext     = r_state;
        w_sdaOeNext     = r_sdaOe;
        w_rxDataNext    = r_rxData;
        w_rxValidNext   = 1'b0;
        w_rxFirstNext   = 1'b0;
        w_txReqNext     = 1'b0;
        w_addressedNext = r_addressed;
        w_stopDetNext   = 1'b0;
        w_shiftNext     = r_shift;
        w_bitCntNext    = r_bitCnt;
        w_firstFlagNext = r_firstFlag;
        w_txShiftNext   = r_txShift;

        if (w_start) begin
            w_stateNext     = S_ADDR;
            w_bitCntNext    = 3'd0;
            w_addressedNext = 1'b0;
            w_sdaOeNext     = 1'b0;
        end else if (w_stop) begin
            w_stateNext     = S_IDLE;
            w_sdaOeNext     = 1'b0;
            w_addressedNext = 1'b0;
            w_stopDetNext   = 1'b1;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byte[6:0];
                        w_bitCntNext = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            w_stateNext = (w_byte[7:1] == ADDR) ? S_ADDR_END : S_IGNORE;
                        end
                    end
                end
                S_ADDR_END: begin
                    if (w_sclFall) begin
                        w_sdaOeNext     = 1'b1;
                        w_addressedNext = 1'b1;
                        w_stateNext     = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_sclFall) begin
                        w_bitCntNext = 3'd0;
                        if (!r_shift[0]) begin
                            w_sdaOeNext     = 1'b0;
                            w_firstFlagNext = 1'b1;
                            w_stateNext     = S_WRITE;
                        end else begin
                            w_txShiftNext = i_tx_data[6:0];
                            w_txReqNext   = 1'b1;
                            w_sdaOeNext   = ~i_tx_data[7];
                            w_stateNext   = S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byte[6:0];
                        w_bitCntNext = r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            w_rxDataNext    = w_byte;
                            w_rxValidNext   = 1'b1;
                            w_rxFirstNext   = r_firstFlag;
                            w_firstFlagNext = 1'b0;
                            w_stateNext     = S_WRITE_END;
                        end
                    end
                end
                S_WRITE_END: begin
                    if (w_sclFall) begin
                        w_sdaOeNext = 1'b1;
                        w_stateNext = S_WRITE_ACK;
                    end
                end
                S_WRITE_ACK: begin
                    if (w_sclFall) begin
                        w_sdaOeNext  = 1'b0;
                        w_bitCntNext = 3'd0;
                        w_stateNext  = S_WRITE;
                    end
                end
                S_READ: begin
                    if (w_sclFall) begin
                        if (r_bitCnt == 3'd7) begin
                            w_sdaOeNext  = 1'b0;
                            w_bitCntNext = 3'd0;
                            w_stateNext  = S_READ_ACK;
                        end else begin
                            w_sdaOeNext   = ~r_txShift[6];
                            w_txShiftNext = {r_txShift[5:0], 1'b0};
                            w_bitCntNext  = r_bitCnt + 3'd1;
                        end
                    end
                end
                S_READ_ACK: begin
                    if (w_sclRise) begin
                        if (r_sdaFilt) begin
                            w_addressedNext = 1'b0;
                            w_stateNext     = S_IGNORE;
                        end else begin
                            w_stateNext     = S_READ_NEXT;
                        end
                    end
                end
                S_READ_NEXT: begin
                    if (w_sclFall) begin
                        w_txShiftNext = i_tx_data[6:0];
                        w_txReqNext   = 1'b1;
                        w_sdaOeNext   = ~i_tx_data[7];
                        w_bitCntNext  = 3'd0;
                        w_stateNext   = S_READ;
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase
        end
    end

    // Datapath and output registers; reset releases SDA immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sdaOe     <= 1'b0;
            r_rxData    <= 8'h00;
            r_rxValid   <= 1'b0;
            r_rxFirst   <= 1'b0;
            r_txReq     <= 1'b0;
            r_addressed <= 1'b0;
            r_stopDet   <= 1'b0;
            r_shift     <= 7'h00;
            r_bitCnt    <= 3'd0;
            r_firstFlag <= 1'b0;
            r_txShift   <= 7'h00;
        end else begin
            r_sdaOe     <= w_sdaOeNext;
            r_rxData    <= w_rxDataNext;
            r_rxValid   <= w_rxValidNext;
            r_rxFirst   <= w_rxFirstNext;
            r_txReq     <= w_txReqNext;
            r_addressed <= w_addressedNext;
            r_stopDet   <= w_stopDetNext;
            r_shift     <= w_shiftNext;
            r_bitCnt    <= w_bitCntNext;
            r_firstFlag <= w_firstFlagNext;
            r_txShift   <= w_txShiftNext;
        end
    end

    assign o_sda_oe    = r_sdaOe;
    assign o_rx_data   = r_rxData;
    assign o_rx_valid  = r_rxValid;
    assign o_rx_first  = r_rxFirst;
    assign o_tx_req    = r_txReq;
    assign o_addressed = r_addressed;
    assign o_stop_det  = r_stopDet;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master drives the bus, a transaction-level
// model predicts ACKs, received bytes, read data and the addressed flag, and one
// compare process checks the DUT against that prediction every cycle.
module tb_i2c_target;

    localparam logic [6:0] ADDR     = 7'h3C;
    localparam int         FILT_LEN = 3;
    localparam int         QTR      = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       mScl;
    logic       mSda;
    logic       sdaBus;
    logic       sdaOe;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxFirst;
    logic [7:0] txData;
    logic       txReq;
    logic       addressed;
    logic       stopDet;

    logic [7:0] txList [256];
    int         txIdx = 0;

    int nChecks = 0;
    int nPass   = 0;

    // Model of what the target must do, kept at transaction level.
    bit         mAddressed  = 0;
    int         mMode       = 0;
    bit         mFirst      = 0;
    bit         mAfterStart = 0;
    int         mTxIdx      = 0;
    int         expStops    = 0;
    logic [8:0] expRx [$];

    // Per-cycle expectations published by the master for the compare process.
    bit chkOe        = 1;
    bit expOe        = 0;
    bit chkAddr      = 0;
    bit expAddressed = 0;

    int         stopsSeen = 0;
    int         txReqSeen = 0;
    logic [7:0] rxLog [$];
    logic       rxFirstLog [$];

    always #5 clk = ~clk;

    assign sdaBus = mSda & ~sdaOe;
    assign txData = txList[txIdx % 256];

    i2c_target #(.ADDR(ADDR), .FILT_LEN(FILT_LEN)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl_in   (mScl),
        .i_sda_in   (sdaBus),
        .o_sda_oe   (sdaOe),
        .o_rx_data  (rxData),
        .o_rx_valid (rxValid),
        .o_rx_first (rxFirst),
        .i_tx_data  (txData),
        .o_tx_req   (txReq),
        .o_addressed(addressed),
        .o_stop_det (stopDet)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Compare process: DUT outputs against the model every cycle they are meaningful.
    always @(negedge clk) begin
        if (!rst) begin
            if (mScl && chkOe)   checkOutput("sdaOeWhileSclHigh", sdaOe, expOe);
            if (mScl && chkAddr) checkOutput("addressedFlag", addressed, expAddressed);
            if (rxValid || txReq) checkOutput("rxTxExclusive", rxValid & txReq, 0);
            if (rxValid) begin
                rxLog.push_back(rxData);
                rxFirstLog.push_back(rxFirst);
                checkOutput("rxExpected", expRx.size() > 0, 1);
                if (expRx.size() > 0) begin
                    checkOutput("rxData", rxData, expRx[0][7:0]);
                    checkOutput("rxFirst", rxFirst, expRx[0][8]);
                    void'(expRx.pop_front());
                end
            end
            if (txReq) begin
                txReqSeen++;
                txIdx++;
            end
            if (stopDet) stopsSeen++;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bitSlot(input logic sdaVal, output logic sampled);
        mSda = sdaVal;
        waitClk(QTR);
        mScl = 1'b1;
        waitClk(QTR);
        sampled = sdaBus;
        waitClk(QTR);
        mScl = 1'b0;
        waitClk(QTR);
    endtask

    task automatic busStart();
        chkAddr = 0;
        expOe   = 0;
        mSda = 1'b1;
        waitClk(QTR);
        mScl = 1'b1;
        waitClk(QTR);
        mSda = 1'b0;
        waitClk(QTR);
        mScl = 1'b0;
        waitClk(QTR);
        mAddressed = 0; mMode = 0; mAfterStart = 1;
    endtask

    task automatic busStop();
        chkAddr = 0;
        expOe   = 0;
        mSda = 1'b0;
        waitClk(QTR);
        mScl = 1'b1;
        waitClk(QTR);
        mSda = 1'b1;
        waitClk(2 * QTR);
        expStops++;
        mAddressed = 0; mMode = 0; mAfterStart = 0;
    endtask

    task automatic sendBits(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) bitSlot(b[i], s);
    endtask

    // Master write of one byte; returns the SDA level seen in the ACK slot (0 = ACK).
    task automatic writeByte(input logic [7:0] b, output logic ackBit);
        bit isAddr = mAfterStart;
        bit expAck;
        if (isAddr) begin
            expAck = (b[7:1] == ADDR);
            expAddressed = 0;
        end else if (mMode == 1) begin
            expAck = 1;
            expRx.push_back({mFirst, b});
            mFirst = 0;
            expAddressed = 1;
        end else begin
            expAck = 0;
            expAddressed = 0;
        end
        chkAddr = 1;
        expOe   = 0;
        sendBits(b);
        expOe = expAck;
        if (isAddr && expAck) expAddressed = 1;
        bitSlot(1'b1, ackBit);
        expOe = 0;
        checkOutput("ackSlot", ackBit, expAck ? 0 : 1);
        if (isAddr) begin
            mAfterStart = 0;
            if (expAck) begin
                mAddressed = 1;
                mMode = b[0] ? 2 : 1;
                mFirst = 1;
            end else begin
                mMode = 0;
            end
        end
    endtask

    // Master read of one byte, then ACK (masterAck=1) or NACK.
    task automatic readByte(input bit masterAck, output logic [7:0] got);
        logic [7:0] exp = txList[mTxIdx % 256];
        logic s;
        mTxIdx++;
        chkAddr = 1;
        expAddressed = 1;
        for (int i = 7; i >= 0; i--) begin
            expOe = ~exp[i];
            bitSlot(1'b1, s);
            got[i] = s;
        end
        expOe = 0;
        chkAddr = masterAck;
        bitSlot(~masterAck, s);
        checkOutput("readByte", got, exp);
        if (!masterAck) begin
            mAddressed = 0;
            mMode = 0;
            expAddressed = 0;
        end
    endtask

    task automatic endTransaction();
        waitClk(20);
        checkOutput("rxDrained", expRx.size(), 0);
        checkOutput("txReqCount", txReqSeen, mTxIdx);
        checkOutput("stopCount", stopsSeen, expStops);
        checkOutput("addressedIdle", addressed, 0);
    endtask

    // One randomized transaction: random address/direction, optional repeated START.
    task automatic applyStimulus();
        int segs = ($urandom_range(0, 3) == 0) ? 2 : 1;
        logic a;
        logic [7:0] g;
        busStart();
        for (int s = 0; s < segs; s++) begin
            logic [6:0] addr = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom_range(0, 127));
            int nb = $urandom_range(1, 2);
            if (s > 0) busStart();
            writeByte({addr, 1'($urandom_range(0, 1))}, a);
            if (mMode == 1) begin
                for (int k = 0; k < nb; k++) writeByte(8'($urandom_range(0, 255)), a);
            end else if (mMode == 2) begin
                for (int k = 0; k < nb; k++) readByte(k != nb - 1, g);
            end else begin
                writeByte(8'($urandom_range(0, 255)), a);
            end
        end
        busStop();
        endTransaction();
    endtask

    initial begin
        logic a0, a1, a2;
        logic [7:0] g0, g1;
        int s0;

        for (int i = 0; i < 256; i++) txList[i] = 8'($urandom_range(0, 255));
        rst = 1'b1; mScl = 1'b1; mSda = 1'b1;
        waitClk(5);
        checkOutput("rstSdaOe", sdaOe, 0);
        checkOutput("rstRxData", rxData, 0);
        checkOutput("rstRxValid", rxValid, 0);
        checkOutput("rstRxFirst", rxFirst, 0);
        checkOutput("rstTxReq", txReq, 0);
        checkOutput("rstAddressed", addressed, 0);
        checkOutput("rstStopDet", stopDet, 0);
        rst = 1'b0;
        waitClk(20);

        $display("[TB] write 0x3C: A5, 00");
        busStart();
        writeByte(8'h78, a0);
        writeByte(8'hA5, a1);
        writeByte(8'h00, a2);
        busStop();
        endTransaction();
        checkOutput("ackBit9", a0, 0);
        checkOutput("ackBit18", a1, 0);
        checkOutput("ackBit27", a2, 0);
        checkOutput("rxCountT1", rxLog.size(), 2);
        if (rxLog.size() >= 2) begin
            checkOutput("rxByte0", rxLog[0], 8'hA5);
            checkOutput("rxFirst0", rxFirstLog[0], 1);
            checkOutput("rxByte1", rxLog[1], 8'h00);
            checkOutput("rxFirst1", rxFirstLog[1], 0);
        end
        checkOutput("stopsT1", stopsSeen, 1);

        $display("[TB] write to foreign address 0x3D");
        busStart();
        writeByte(8'h7A, a0);
        writeByte(8'hFF, a1);
        busStop();
        endTransaction();
        checkOutput("nackForeignAddr", a0, 1);
        checkOutput("nackForeignData", a1, 1);
        checkOutput("rxCountT2", rxLog.size(), 2);

        $display("[TB] read 0x5A, 0xC3");
        txList[mTxIdx % 256]       = 8'h5A;
        txList[(mTxIdx + 1) % 256] = 8'hC3;
        busStart();
        writeByte(8'h79, a0);
        readByte(1, g0);
        readByte(0, g1);
        checkOutput("addressedAfterNack", addressed, 0);
        checkOutput("sdaReleasedAfterNack", sdaOe, 0);
        busStop();
        endTransaction();
        checkOutput("readAck", a0, 0);
        checkOutput("readData0", g0, 8'h5A);
        checkOutput("readData1", g1, 8'hC3);
        checkOutput("txReqT3", txReqSeen, 2);

        $display("[TB] write then repeated START read");
        busStart();
        writeByte(8'h78, a0);
        writeByte(8'h11, a1);
        busStart();
        writeByte(8'h79, a2);
        readByte(0, g0);
        busStop();
        endTransaction();
        checkOutput("rxAfterRestart", rxLog[rxLog.size() - 1], 8'h11);
        checkOutput("readAckAfterRestart", a2, 0);

        $display("[TB] SDA glitches in idle");
        for (int i = 0; i < 6; i++) begin
            int len = (i == 0) ? FILT_LEN - 1 : (i == 1) ? FILT_LEN : $urandom_range(1, FILT_LEN + 2);
            s0 = stopsSeen;
            mSda = 1'b0;
            waitClk(len);
            mSda = 1'b1;
            waitClk(30);
            if (len >= FILT_LEN) expStops++;
            checkOutput("glitchStop", stopsSeen - s0, (len >= FILT_LEN) ? 1 : 0);
        end

        $display("[TB] reset during address ACK");
        busStart();
        chkAddr = 1; expAddressed = 0; expOe = 0;
        sendBits(8'h78);
        mSda = 1'b1;
        checkOutput("oeBeforeReset", sdaOe, 1);
        #2 rst = 1'b1;
        #1 checkOutput("oeAsyncReset", sdaOe, 0);
        checkOutput("addressedAsyncReset", addressed, 0);
        waitClk(4);
        rst = 1'b0;
        chkAddr = 0;
        mAddressed = 0; mMode = 0; mAfterStart = 0;
        waitClk(10);
        mScl = 1'b1;
        waitClk(QTR);
        busStart();
        writeByte(8'h78, a0);
        writeByte(8'h3C, a1);
        busStop();
        endTransaction();
        checkOutput("postResetAck", a0, 0);
        checkOutput("postResetRx", rxLog[rxLog.size() - 1], 8'h3C);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 8; t++) applyStimulus();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
